fifo_rr_arbiter: RTL and testbench

//  Round-robin merger that shares one downstream fifo_gen write port among NCH

---
 rtl/fifo_rr_arbiter.sv | 99 +++++++++
 tb/tb_fifo_rr_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// Round-robin merger: NCH ap_fifo read ports onto one ap_fifo write port,
// holding each grant for up to BURST tokens and tagging every token with its source.
module fifo_rr_arbiter #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NCH-1:0]           in_empty_n,
  input  logic [NCH*WIDTH-1:0]     in_dout,
  output logic [NCH-1:0]           in_read,
  input  logic                     out_full_n,
  output logic [WIDTH-1:0]         out_din,
  output logic [$clog2(NCH)-1:0]   out_tag,
  output logic                     out_write,
  output logic                     busy
);

  localparam int TW = $clog2(NCH);
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [TW-1:0]   grant;
  logic [TW-1:0]   ptr;
  logic [TW-1:0]   sel;
  logic [CW-1:0]   cnt;
  logic            g_avail;
  logic            xfer;
  logic            last;

  // First requesting channel after ptr; descending scan so the nearest one wins.
  always_comb begin
    sel = ptr;
    for (int k = NCH; k >= 1; k--) begin
      if (in_empty_n[(int'(ptr) + k) % NCH]) sel = TW'((int'(ptr) + k) % NCH);
    end
  end

  // Handshake: a token moves only in a cycle where in_read[g] and out_write are
  // both high; that happens exactly when the granted source is not empty, the
  // sink is not full and enable is set. Nothing is buffered inside.
  assign g_avail = in_empty_n[grant];
  assign xfer    = (state == GRANT) && enable && g_avail && out_full_n;
  assign last    = (cnt == CW'(BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= TW'(NCH - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && (|in_empty_n)) begin
            grant <= sel;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            if (last) begin
              state <= IDLE;
              ptr   <= grant;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (enable && !g_avail) begin
            state <= IDLE;
            ptr   <= grant;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are combinational from registered state and register-derived FIFO flags,
  // so no loop forms through fifo_gen.
  always_comb begin
    busy       = (state == GRANT);
    out_write  = xfer;
    in_read    = '0;
    in_read[grant] = xfer;
    out_tag    = busy ? grant : '0;
    out_din    = busy ? in_dout[int'(grant)*WIDTH +: WIDTH] : '0;
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: upstream FIFOs modelled as queues, a transaction-level
// round-robin model fills the expected queue, and every write is scored against it.
module tb_fifo_rr_arbiter;

  localparam int NCH   = 4;
  localparam int W     = 8;
  localparam int BURST = 4;
  localparam int TW    = $clog2(NCH);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b1;
  logic              out_full_n = 1'b1;
  logic [NCH-1:0]    in_empty_n = '0;
  logic [NCH*W-1:0]  in_dout = '0;
  logic [NCH-1:0]    in_read;
  logic [W-1:0]      out_din;
  logic [TW-1:0]     out_tag;
  logic              out_write;
  logic              busy;

  fifo_rr_arbiter #(.NCH(NCH), .WIDTH(W), .BURST(BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_empty_n (in_empty_n),
    .in_dout    (in_dout),
    .in_read    (in_read),
    .out_full_n (out_full_n),
    .out_din    (out_din),
    .out_tag    (out_tag),
    .out_write  (out_write),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int                n_cmp = 0;
  int                n_bad = 0;
  int                n_writes = 0;
  int                m_ptr = NCH - 1;
  logic [W-1:0]      up_q[NCH][$];
  logic [TW+W-1:0]   exp_q[$];
  logic              s_busy, s_write;
  logic [W-1:0]      s_din;
  logic [TW-1:0]     s_tag;
  logic [NCH-1:0]    s_read;

  typedef struct {
    logic          en;
    logic          full;
    logic          e_busy;
    logic          e_write;
    logic [W-1:0]  e_din;
    logic [TW-1:0] e_tag;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int i = 0; i < NCH; i++) begin
      in_empty_n[i]     = (up_q[i].size() != 0);
      in_dout[i*W +: W] = (up_q[i].size() != 0) ? up_q[i][0] : '0;
    end
  endtask

  task automatic load(input int ch, input int base, input int n);
    for (int j = 0; j < n; j++) up_q[ch].push_back(W'(base + j));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    enable = 1'b1;
    out_full_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NCH; i++) up_q[i].delete();
    m_ptr = NCH - 1;
    drive_inputs();
  endtask

  // Released just after a rising edge so the next tick samples the first IDLE cycle.
  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference model: whole-transaction view of round-robin with bursts of BURST.
  task automatic build_expected();
    logic [W-1:0] c[NCH][$];
    int left, sel, n;
    left = 0;
    for (int i = 0; i < NCH; i++) begin
      c[i] = up_q[i];
      left += c[i].size();
    end
    while (left > 0) begin
      sel = -1;
      for (int k = 1; k <= NCH; k++)
        if (sel < 0 && c[(m_ptr + k) % NCH].size() != 0) sel = (m_ptr + k) % NCH;
      n = (c[sel].size() < BURST) ? c[sel].size() : BURST;
      for (int j = 0; j < n; j++) exp_q.push_back({TW'(sel), c[sel].pop_front()});
      left -= n;
      m_ptr = sel;
    end
  endtask

  // One clock: sample outputs at negedge, score writes, then pop the upstream queues.
  task automatic tick();
    logic [TW+W-1:0] e;
    @(negedge clk);
    s_busy  = busy;
    s_write = out_write;
    s_din   = out_din;
    s_tag   = out_tag;
    s_read  = in_read;
    if (s_write) begin
      n_writes++;
      check("read_onehot", 32'(s_read), 32'(1) << s_tag);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got tag %0d data 0x%0h, expected no write", s_tag, s_din);
      end else begin
        e = exp_q.pop_front();
        check("token", 32'({s_tag, s_din}), 32'(e));
      end
    end else begin
      check("read_without_write", 32'(s_read), 32'(0));
    end
    @(posedge clk);
    for (int i = 0; i < NCH; i++)
      if (s_read[i] && up_q[i].size() != 0) void'(up_q[i].pop_front());
    #1 drive_inputs();
  endtask

  task automatic drain(input bit rnd);
    int budget, left;
    budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      if (rnd) begin
        enable     = ($urandom_range(0, 3) != 0);
        out_full_n = ($urandom_range(0, 3) != 0);
      end
      tick();
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d tokens unwritten, expected 0", exp_q.size());
    end
    enable = 1'b1;
    out_full_n = 1'b1;
    tick();
    tick();
    check("idle_after_drain", 32'(s_busy), 32'(0));
    left = 0;
    for (int i = 0; i < NCH; i++) left += up_q[i].size();
    check("upstream_empty", 32'(left), 32'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cycles;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 2'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 2'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 2'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 2'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 2'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

    #2;
    // 1: reset values, then a 6-token single-channel run checked cycle by cycle
    do_reset();
    load(0, 'h10, 6);
    drive_inputs();
    #1;
    check("rst_busy",  32'(busy), 32'(0));
    check("rst_write", 32'(out_write), 32'(0));
    check("rst_read",  32'(in_read), 32'(0));
    check("rst_din",   32'(out_din), 32'(0));
    check("rst_tag",   32'(out_tag), 32'(0));
    build_expected();
    release_rst();
    for (int i = 0; i < 11; i++) begin
      enable     = tbl[i].en;
      out_full_n = tbl[i].full;
      tick();
      check($sformatf("vec%0d_busy", i),  32'(s_busy),  32'(tbl[i].e_busy));
      check($sformatf("vec%0d_write", i), 32'(s_write), 32'(tbl[i].e_write));
      if (tbl[i].e_busy) check($sformatf("vec%0d_tag", i), 32'(s_tag), 32'(tbl[i].e_tag));
      if (tbl[i].e_write) check($sformatf("vec%0d_din", i), 32'(s_din), 32'(tbl[i].e_din));
    end
    drain(1'b0);

    // 2: all channels 8 deep -> 8 grants of 4, last write on cycle 40
    do_reset();
    for (int i = 0; i < NCH; i++) load(i, i * 'h10 + 'h20, 8);
    drive_inputs();
    build_expected();
    release_rst();
    n_writes = 0;
    cycles = 0;
    while (n_writes < 32 && cycles < 100) begin
      tick();
      cycles++;
    end
    check("full_rr_cycles", 32'(cycles), 32'(40));
    drain(1'b0);

    // 3: ch1 alone releases on empty; then ch2 beats ch0
    do_reset();
    load(1, 'h31, 2);
    drive_inputs();
    build_expected();
    release_rst();
    drain(1'b0);
    load(0, 'h3A, 1);
    load(2, 'h3B, 1);
    drive_inputs();
    build_expected();
    tick();
    tick();
    check("rr_after_release_write", 32'(s_write), 32'(1));
    check("rr_after_release_tag",   32'(s_tag),   32'(2));
    drain(1'b0);

    // 4: downstream full mid-burst holds grant and count
    do_reset();
    load(0, 'h40, 6);
    drive_inputs();
    build_expected();
    release_rst();
    tick();
    tick();
    tick();
    out_full_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_stall_write", 32'(s_write), 32'(0));
      check("full_stall_busy",  32'(s_busy),  32'(1));
    end
    out_full_n = 1'b1;
    tick();
    check("resume_write3", 32'(s_write), 32'(1));
    tick();
    check("resume_write4", 32'(s_write), 32'(1));
    tick();
    check("burst_end_idle", 32'(s_busy), 32'(0));
    drain(1'b0);

    // 5: enable low in IDLE and in GRANT
    do_reset();
    enable = 1'b0;
    load(3, 'h55, 1);
    drive_inputs();
    build_expected();
    release_rst();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dis_idle_busy",  32'(s_busy),  32'(0));
      check("dis_idle_write", 32'(s_write), 32'(0));
    end
    enable = 1'b1;
    tick();
    tick();
    check("en_write", 32'(s_write), 32'(1));
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("dis_grant_busy",  32'(s_busy),  32'(1));
      check("dis_grant_write", 32'(s_write), 32'(0));
    end
    enable = 1'b1;
    tick();
    check("empty_release_busy",  32'(s_busy),  32'(1));
    check("empty_release_write", 32'(s_write), 32'(0));
    tick();
    check("empty_release_idle", 32'(s_busy), 32'(0));

    // 6: reset while the second token is on the bus
    do_reset();
    load(0, 'h60, 6);
    load(1, 'h70, 3);
    drive_inputs();
    build_expected();
    release_rst();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_write", 32'(out_write), 32'(0));
    check("midrst_read",  32'(in_read),   32'(0));
    check("midrst_busy",  32'(busy),      32'(0));
    exp_q.delete();
    m_ptr = NCH - 1;
    build_expected();
    release_rst();
    drain(1'b0);

    // randomized rounds against the model
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < NCH; i++) begin
        int n;
        n = $urandom_range(0, 10);
        for (int j = 0; j < n; j++) up_q[i].push_back(W'($urandom));
      end
      drive_inputs();
      build_expected();
      release_rst();
      drain(1'b1);
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
